// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers {pc, instr} words in a DEPTH-entry ring.
// Latency: a word fetched at edge N is presented with deq_valid in cycle N+1 (no bypass).
// Backpressure: deq_ready low holds the head; fetch stops when full unless the head leaves the same cycle.
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 9,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [DATA_W-1:0]        deq_instr,
  output logic [ADDR_W-1:0]        deq_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic deq_fire;
  logic enq;

  // Redirect targets are word aligned; the two low address bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  // A redirecting cycle must not hand a wrong-path instruction to IF/ID.
  assign deq_valid = ~empty & ~redirect;
  assign deq_fire  = deq_valid & deq_ready;
  // When full, a departing head frees its slot in time for this cycle's write.
  assign enq       = fetch_en & ~redirect & (~full | deq_fire);

  assign imem_addr = fetch_pc;
  assign deq_instr = instr_mem[head];
  assign deq_pc    = pc_mem[head];
  assign count     = cnt;

  // Fetch PC: reset vector, redirect target, or next sequential word after each enqueue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (enq) begin
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // Ring pointers and occupancy; a redirect discards everything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (redirect) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (deq_fire) head <= head + PW'(1);
      if (enq)      tail <= tail + PW'(1);
      if (enq && !deq_fire)      cnt <= cnt + CW'(1);
      else if (!enq && deq_fire) cnt <= cnt - CW'(1);
    end
  end

  // Entry storage; cleared at reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (enq) begin
      instr_mem[tail] <= imem_data;
      pc_mem[tail]    <= fetch_pc;
    end
  end

endmodule
